ps2_kbd_ctrl: RTL and testbench

//  Controller that drains the PS/2 receiver scan-code FIFO and turns the raw byte stream into key events.

---
 rtl/ps2_kbd_pkg.sv | 20 ++
 rtl/ps2_scan_to_ascii.sv | 36 +++
 rtl/ps2_kbd_ctrl.sv | 114 +++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared scan-code constants and controller state encoding
package ps2_kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   typedef enum logic [1:0] {
      IDLE,
      POP,
      DEC
   } kbd_state_t;

   function automatic logic is_shift(input logic [7:0] code);
      return (code == SC_LSHIFT) || (code == SC_RSHIFT);
   endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// rtl/ps2_scan_to_ascii.sv - set-2 make code to ASCII table, letters case-switched by upper
module ps2_scan_to_ascii (
   input  logic [7:0] code,
   input  logic       upper,
   output logic [7:0] ascii
);

   logic [7:0] base;

   always_comb begin
      base = 8'h00;
      case (code)
         8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
         8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
         8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
         8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
         8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
         8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
         8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
         8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
         8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
         8'h45: base = 8'h30;  8'h16: base = 8'h31;  8'h1E: base = 8'h32;
         8'h26: base = 8'h33;  8'h25: base = 8'h34;  8'h2E: base = 8'h35;
         8'h36: base = 8'h36;  8'h3D: base = 8'h37;  8'h3E: base = 8'h38;
         8'h46: base = 8'h39;
         8'h29: base = 8'h20;
         8'h5A: base = 8'h0D;
         8'h66: base = 8'h08;
         default: base = 8'h00;
      endcase
   end

   // Only the lowercase letter range is case-shifted; digits and controls pass through.
   assign ascii = (upper && base >= 8'h61 && base <= 8'h7A) ? base - 8'h20 : base;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - drains the PS/2 scan-code FIFO and decodes key events
module ps2_kbd_ctrl
   import ps2_kbd_pkg::*;
#(
   parameter int PRESS_CNT_W   = 8,
   parameter int REPEAT_FILTER = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   kbd_ready,
   input  logic [7:0]             kbd_data,
   input  logic                   kbd_ovf,
   output logic                   nextdata_n,
   output logic                   key_valid,
   output logic [7:0]             key_code,
   output logic                   key_ext,
   output logic [7:0]             key_ascii,
   output logic                   key_down,
   output logic                   shift_on,
   output logic                   caps_on,
   output logic [PRESS_CNT_W-1:0] press_count,
   output logic                   err_ovf
);

   kbd_state_t state;
   logic [7:0] byte_r;
   logic       ext_r, brk_r, lshift_r, rshift_r, caps_held_r;
   logic [7:0] ascii_w;
   logic       is_repeat;

   assign shift_on  = lshift_r | rshift_r;
   assign is_repeat = (REPEAT_FILTER != 0) && key_down &&
                      (byte_r == key_code) && (ext_r == key_ext);

   ps2_scan_to_ascii u_scan_to_ascii (
      .code  (byte_r),
      .upper (shift_on ^ caps_on),
      .ascii (ascii_w)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         nextdata_n  <= 1'b1;
         byte_r      <= 8'h00;
         ext_r       <= 1'b0;
         brk_r       <= 1'b0;
         lshift_r    <= 1'b0;
         rshift_r    <= 1'b0;
         caps_held_r <= 1'b0;
         key_valid   <= 1'b0;
         key_code    <= 8'h00;
         key_ext     <= 1'b0;
         key_ascii   <= 8'h00;
         key_down    <= 1'b0;
         caps_on     <= 1'b0;
         press_count <= '0;
         err_ovf     <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         err_ovf   <= err_ovf | kbd_ovf;
         case (state)
            IDLE: begin
               if (kbd_ready) begin
                  byte_r     <= kbd_data;
                  nextdata_n <= 1'b0;
                  state      <= POP;
               end
            end
            POP: begin
               nextdata_n <= 1'b1;
               state      <= DEC;
            end
            DEC: begin
               state <= IDLE;
               if (byte_r == SC_EXT) begin
                  ext_r <= 1'b1;
               end else if (byte_r == SC_BREAK) begin
                  brk_r <= 1'b1;
               end else if (brk_r) begin
                  if (byte_r == SC_LSHIFT) lshift_r <= 1'b0;
                  if (byte_r == SC_RSHIFT) rshift_r <= 1'b0;
                  if (byte_r == SC_CAPS)   caps_held_r <= 1'b0;
                  if (byte_r == key_code && ext_r == key_ext) key_down <= 1'b0;
                  ext_r <= 1'b0;
                  brk_r <= 1'b0;
               end else begin
                  ext_r <= 1'b0;
                  if (is_shift(byte_r)) begin
                     if (byte_r == SC_LSHIFT) lshift_r <= 1'b1;
                     else                     rshift_r <= 1'b1;
                  end else if (byte_r == SC_CAPS) begin
                     // Typematic repeats of CapsLock must not keep toggling it.
                     if (!caps_held_r) caps_on <= ~caps_on;
                     caps_held_r <= 1'b1;
                  end else if (!is_repeat) begin
                     key_code    <= byte_r;
                     key_ext     <= ext_r;
                     key_ascii   <= ext_r ? 8'h00 : ascii_w;
                     key_down    <= 1'b1;
                     press_count <= press_count + 1'b1;
                     key_valid   <= 1'b1;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               nextdata_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - directed and random byte streams checked against a key-event model
module tb_ps2_kbd_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic kbd_ready = 1'b0;
   logic [7:0] kbd_data = 8'h00;
   logic kbd_ovf = 1'b0;

   logic [1:0] nd, kv, kext, kdown, sh, cp, eo;
   logic [7:0] kc [2];
   logic [7:0] ka [2];
   logic [7:0] pc [2];

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit ext, brk, lsh, rsh, caps, held, down, kext, err;
      bit [7:0] code, ascii, count;
   } model_t;
   model_t m [2];

   logic [7:0] q [$];
   logic [7:0] lc;
   bit lext;

   always #5 clk = ~clk;

   ps2_kbd_ctrl #(.PRESS_CNT_W(8), .REPEAT_FILTER(1)) dut0 (
      .clk(clk), .reset(reset), .kbd_ready(kbd_ready), .kbd_data(kbd_data), .kbd_ovf(kbd_ovf),
      .nextdata_n(nd[0]), .key_valid(kv[0]), .key_code(kc[0]), .key_ext(kext[0]),
      .key_ascii(ka[0]), .key_down(kdown[0]), .shift_on(sh[0]), .caps_on(cp[0]),
      .press_count(pc[0]), .err_ovf(eo[0])
   );

   ps2_kbd_ctrl #(.PRESS_CNT_W(8), .REPEAT_FILTER(0)) dut1 (
      .clk(clk), .reset(reset), .kbd_ready(kbd_ready), .kbd_data(kbd_data), .kbd_ovf(kbd_ovf),
      .nextdata_n(nd[1]), .key_valid(kv[1]), .key_code(kc[1]), .key_ext(kext[1]),
      .key_ascii(ka[1]), .key_down(kdown[1]), .shift_on(sh[1]), .caps_on(cp[1]),
      .press_count(pc[1]), .err_ovf(eo[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit [7:0] ref_ascii(input bit [7:0] c, input bit up);
      bit [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
      bit [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      for (int i = 0; i < 26; i++)
         if (c == letters[i]) return 8'((up ? 65 : 97) + i);
      for (int i = 0; i < 10; i++)
         if (c == digits[i]) return 8'(48 + i);
      if (c == 8'h29) return 8'h20;
      if (c == 8'h5A) return 8'h0D;
      if (c == 8'h66) return 8'h08;
      return 8'h00;
   endfunction

   function automatic bit model_apply(input int i, input bit [7:0] b);
      bit filt = (i == 0);
      bit ev = 0;
      if (b == 8'hE0) m[i].ext = 1;
      else if (b == 8'hF0) m[i].brk = 1;
      else if (m[i].brk) begin
         if (b == 8'h12) m[i].lsh = 0;
         if (b == 8'h59) m[i].rsh = 0;
         if (b == 8'h58) m[i].held = 0;
         if (b == m[i].code && m[i].ext == m[i].kext) m[i].down = 0;
         m[i].ext = 0;
         m[i].brk = 0;
      end else begin
         if (b == 8'h12) m[i].lsh = 1;
         else if (b == 8'h59) m[i].rsh = 1;
         else if (b == 8'h58) begin
            if (!m[i].held) m[i].caps = !m[i].caps;
            m[i].held = 1;
         end else if (!(filt && m[i].down && b == m[i].code && m[i].ext == m[i].kext)) begin
            m[i].ascii = m[i].ext ? 8'h00 : ref_ascii(b, (m[i].lsh | m[i].rsh) ^ m[i].caps);
            m[i].code  = b;
            m[i].kext  = m[i].ext;
            m[i].down  = 1;
            m[i].count = m[i].count + 8'd1;
            ev = 1;
         end
         m[i].ext = 0;
      end
      return ev;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) m[i] = '{default: 0};
   endtask

   task automatic cmp_all(input bit ev0, input bit ev1, input bit exp_nd);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d_nextdata_n", i), nd[i], exp_nd);
         chk($sformatf("d%0d_key_valid", i), kv[i], (i == 0) ? ev0 : ev1);
         chk($sformatf("d%0d_key_code", i), kc[i], m[i].code);
         chk($sformatf("d%0d_key_ext", i), kext[i], m[i].kext);
         chk($sformatf("d%0d_key_ascii", i), ka[i], m[i].ascii);
         chk($sformatf("d%0d_key_down", i), kdown[i], m[i].down);
         chk($sformatf("d%0d_shift_on", i), sh[i], m[i].lsh | m[i].rsh);
         chk($sformatf("d%0d_caps_on", i), cp[i], m[i].caps);
         chk($sformatf("d%0d_press_count", i), pc[i], m[i].count);
         chk($sformatf("d%0d_err_ovf", i), eo[i], m[i].err);
      end
   endtask

   // Ready is held high while bytes remain: pops land every third cycle and
   // each byte's effect is visible two cycles after its pop.
   task automatic run_q();
      logic [7:0] bq [$];
      int n, sent;
      bit ev0, ev1;
      bq = q;
      q = {};
      n = bq.size();
      sent = 0;
      kbd_ready = (n > 0);
      kbd_data = (n > 0) ? bq[0] : 8'h00;
      for (int cyc = 1; cyc <= 3 * n; cyc++) begin
         @(negedge clk);
         ev0 = 0;
         ev1 = 0;
         if (cyc % 3 == 0) begin
            ev0 = model_apply(0, bq[cyc / 3 - 1]);
            ev1 = model_apply(1, bq[cyc / 3 - 1]);
         end
         cmp_all(ev0, ev1, !(cyc % 3 == 1));
         if (cyc % 3 == 1) begin
            sent++;
            kbd_ready = (sent < n);
            kbd_data = (sent < n) ? bq[sent] : 8'h00;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1;
      kbd_ready = 0;
      kbd_ovf = 0;
      @(negedge clk);
      reset = 0;
      model_reset();
      cmp_all(0, 0, 1);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Plain press and release
      q = '{8'h1C, 8'hF0, 8'h1C};
      run_q();
      chk("t1_count", pc[0], 8'd1);
      chk("t1_ascii", ka[0], 8'h61);
      chk("t1_down_end", kdown[0], 1'b0);

      // Shifted letter
      do_reset();
      q = '{8'h12, 8'h1C};
      run_q();
      chk("t2_shift_held", sh[0], 1'b1);
      chk("t2_ascii", ka[0], 8'h41);
      q = '{8'hF0, 8'h1C, 8'hF0, 8'h12};
      run_q();
      chk("t2_shift_end", sh[0], 1'b0);
      chk("t2_count", pc[0], 8'd1);

      // CapsLock, then Shift cancelling it
      do_reset();
      q = '{8'h58, 8'hF0, 8'h58, 8'h1C};
      run_q();
      chk("t3_caps", cp[0], 1'b1);
      chk("t3_ascii_caps", ka[0], 8'h41);
      q = '{8'h12, 8'h1C};
      run_q();
      chk("t3_ascii_caps_shift_nofilter", ka[1], 8'h61);

      // Typematic repeat filtering
      do_reset();
      q = '{8'h1C, 8'h1C, 8'h1C};
      run_q();
      chk("t4_count_filter", pc[0], 8'd1);
      chk("t4_count_nofilter", pc[1], 8'd3);

      // Extended key, and reset dropping a pending E0
      do_reset();
      q = '{8'hE0, 8'h75};
      run_q();
      chk("t5_ext", kext[0], 1'b1);
      chk("t5_code", kc[0], 8'h75);
      chk("t5_ascii", ka[0], 8'h00);
      q = '{8'hE0, 8'hF0, 8'h75};
      run_q();
      chk("t5_down_end", kdown[0], 1'b0);
      q = '{8'hE0};
      run_q();
      do_reset();
      q = '{8'h75};
      run_q();
      chk("t5_ext_after_reset", kext[0], 1'b0);

      // Reset while the pop strobe is low
      @(negedge clk);
      kbd_ready = 1;
      kbd_data = 8'h1C;
      @(negedge clk);
      chk("midpop_nd_low", nd[0], 1'b0);
      reset = 1;
      kbd_ready = 0;
      @(negedge clk);
      reset = 0;
      model_reset();
      cmp_all(0, 0, 1);

      // Eight queued bytes back to back
      q = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32, 8'h21, 8'h23};
      run_q();

      // Press counter wrap
      do_reset();
      for (int k = 0; k < 256; k++) q.push_back((k % 2) ? 8'h32 : 8'h1C);
      run_q();
      chk("t6_wrap_filter", pc[0], 8'd0);
      chk("t6_wrap_nofilter", pc[1], 8'd0);

      // Overflow flag is sticky
      @(negedge clk);
      kbd_ovf = 1;
      @(negedge clk);
      kbd_ovf = 0;
      m[0].err = 1;
      m[1].err = 1;
      cmp_all(0, 0, 1);

      // Random key traffic
      lc = 8'h1C;
      lext = 0;
      for (int chunk = 0; chunk < 8; chunk++) begin
         for (int t = 0; t < 15; t++) begin
            logic [7:0] pool [12];
            int r;
            pool = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h0D, 8'h1A, 8'h46};
            r = int'($urandom_range(0, 9));
            if (r <= 4) begin
               lext = ($urandom_range(0, 4) == 0);
               if (lext) q.push_back(8'hE0);
               lc = pool[$urandom_range(0, 11)];
               q.push_back(lc);
            end else if (r <= 6) begin
               if (lext) q.push_back(8'hE0);
               q.push_back(8'hF0);
               q.push_back(lc);
            end else if (r == 7) begin
               q.push_back($urandom_range(0, 1) ? 8'h12 : 8'h59);
            end else if (r == 8) begin
               q.push_back(8'hF0);
               q.push_back($urandom_range(0, 1) ? 8'h12 : 8'h59);
            end else begin
               if ($urandom_range(0, 1) != 0) q.push_back(8'hF0);
               q.push_back(8'h58);
            end
         end
         run_q();
      end
      chk("ovf_sticky", eo[0], 1'b1);

      do_reset();
      chk("ovf_cleared", eo[0], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
